// File: rtl/time_set_controller.sv
// Run/set sequencer for the digital clock: mode stepping, increment strobes, blink and idle timeout.
// Define TIME_SET_AUTO_REPEAT_EN to add hold-to-repeat increments in SET_HOUR/SET_MIN.
//
// state    | meaning
// RUN      | time advances, inc ignored, nothing blanked
// SET_HOUR | inc -> hour_inc, hour field blinks
// SET_MIN  | inc -> min_inc, minute field blinks
// SET_SEC  | inc -> sec_clear, second field blinks
module time_set_controller #(
    parameter int BLINK_CYC        = 25_000_000,
    parameter int TIMEOUT_CYC      = 500_000_000,
    parameter int REPEAT_DELAY_CYC = 25_000_000,
    parameter int REPEAT_RATE_CYC  = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_tick,
    input  logic       inc_tick,
    input  logic       inc_level,
    output logic [1:0] mode,
    output logic       run_en,
    output logic       hour_inc,
    output logic       min_inc,
    output logic       sec_clear,
    output logic [2:0] blank
);
    localparam int BLINK_W = $clog2(BLINK_CYC);
    localparam int IDLE_W  = $clog2(TIMEOUT_CYC);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        SET_SEC  = 2'b11
    } state_t;

    state_t               state, state_nxt;
    logic [IDLE_W-1:0]    idle_cnt, idle_nxt;
    logic [BLINK_W-1:0]   blink_cnt, blink_cnt_nxt;
    logic                 blink_phase, blink_phase_nxt;
    logic [2:0]           blank_nxt;
    logic                 timeout, entering, inc_evt, rep_strobe;

    assign timeout = (state != RUN) && (idle_cnt == IDLE_LAST);

`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int HOLD_W   = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE_CYC - 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              held, repeating, hold_ok;

    assign hold_ok    = inc_level && !mode_tick && !timeout && (state == SET_HOUR || state == SET_MIN);
    assign rep_strobe = hold_ok && held && (hold_cnt == (repeating ? RATE_LAST : DELAY_LAST));

    // The first held sample only arms the counter, so the delay counts whole cycles of hold.
    always_ff @(posedge clk) begin
        if (rst || !hold_ok) begin
            held      <= 1'b0;
            repeating <= 1'b0;
            hold_cnt  <= '0;
        end else if (!held) begin
            held     <= 1'b1;
            hold_cnt <= '0;
        end else if (rep_strobe) begin
            repeating <= 1'b1;
            hold_cnt  <= '0;
        end else begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    localparam int unused_repeat_cfg = REPEAT_DELAY_CYC + REPEAT_RATE_CYC;
    logic unused_inc_level;
    assign unused_inc_level = inc_level;
    assign rep_strobe       = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        entering  = 1'b0;
        inc_evt   = 1'b0;
        if (timeout) begin
            state_nxt = RUN;
        end else if (mode_tick) begin
            state_nxt = state_t'(state + 2'd1);
            entering  = (state != SET_SEC);
        end else if (state != RUN && (inc_tick || rep_strobe)) begin
            inc_evt = 1'b1;
        end

        if (state_nxt == RUN || mode_tick || inc_tick || rep_strobe)
            idle_nxt = '0;
        else
            idle_nxt = idle_cnt + 1'b1;

        // Edits restart the blink visible so the field does not vanish mid-adjust.
        blink_cnt_nxt   = blink_cnt + 1'b1;
        blink_phase_nxt = blink_phase;
        if (state_nxt == RUN || entering || inc_evt) begin
            blink_cnt_nxt   = '0;
            blink_phase_nxt = 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt_nxt   = '0;
            blink_phase_nxt = ~blink_phase;
        end

        case (state_nxt)
            SET_HOUR: blank_nxt = {~blink_phase_nxt, 2'b00};
            SET_MIN:  blank_nxt = {1'b0, ~blink_phase_nxt, 1'b0};
            SET_SEC:  blank_nxt = {2'b00, ~blink_phase_nxt};
            default:  blank_nxt = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            idle_cnt    <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            run_en      <= 1'b1;
            hour_inc    <= 1'b0;
            min_inc     <= 1'b0;
            sec_clear   <= 1'b0;
            blank       <= 3'b000;
        end else begin
            state       <= state_nxt;
            idle_cnt    <= idle_nxt;
            blink_cnt   <= blink_cnt_nxt;
            blink_phase <= blink_phase_nxt;
            run_en      <= (state_nxt == RUN);
            hour_inc    <= inc_evt && (state == SET_HOUR);
            min_inc     <= inc_evt && (state == SET_MIN);
            sec_clear   <= inc_evt && (state == SET_SEC);
            blank       <= blank_nxt;
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_time_set_controller.sv
// Scoreboard bench for time_set_controller; expectations follow TIME_SET_AUTO_REPEAT_EN if defined.
module tb_time_set_controller;
    localparam int BLINK = 4;
    localparam int TMO   = 20;
    localparam int RDLY  = 8;
    localparam int RRATE = 3;
`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode_tick = 1'b0;
    logic       inc_tick = 1'b0;
    logic       inc_level = 1'b0;
    logic [1:0] mode;
    logic       run_en, hour_inc, min_inc, sec_clear;
    logic [2:0] blank;

    time_set_controller #(
        .BLINK_CYC(BLINK),
        .TIMEOUT_CYC(TMO),
        .REPEAT_DELAY_CYC(RDLY),
        .REPEAT_RATE_CYC(RRATE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mode_tick(mode_tick),
        .inc_tick(inc_tick),
        .inc_level(inc_level),
        .mode(mode),
        .run_en(run_en),
        .hour_inc(hour_inc),
        .min_inc(min_inc),
        .sec_clear(sec_clear),
        .blank(blank)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [8:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   hour_seen = 0;

    // Spec-level model: timestamps of the last activity / blink restart instead of counters.
    int m_mode = 0, m_act = 0, m_blink = 0, m_run = 0, cyc = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_step(input logic r, input logic mt, input logic it, input logic il,
                              output logic [8:0] v);
        logic       tmo, hold_ok, rep, hs, ms, ss;
        logic [2:0] bl;
        logic [1:0] md;
        int         age;
        hs = 1'b0; ms = 1'b0; ss = 1'b0;
        if (r) begin
            m_mode = 0;
            m_run  = 0;
        end else begin
            tmo     = (m_mode != 0) && (cyc - m_act == TMO);
            hold_ok = REP_EN && il && (m_mode == 1 || m_mode == 2) && !mt && !tmo;
            age     = m_run;
            rep     = hold_ok && (age >= RDLY) && ((age - RDLY) % RRATE == 0);
            m_run   = hold_ok ? age + 1 : 0;
            if (tmo) begin
                m_mode = 0;
            end else if (mt) begin
                m_mode  = (m_mode + 1) % 4;
                m_act   = cyc;
                m_blink = cyc;
            end else if (m_mode != 0 && (it || rep)) begin
                hs = (m_mode == 1);
                ms = (m_mode == 2);
                ss = (m_mode == 3);
                m_act   = cyc;
                m_blink = cyc;
            end
        end
        bl = 3'b000;
        if (m_mode != 0 && ((cyc - m_blink) / BLINK) % 2 == 1)
            bl = (m_mode == 1) ? 3'b100 : (m_mode == 2) ? 3'b010 : 3'b001;
        md = 2'(m_mode);
        v = {md, (m_mode == 0), hs, ms, ss, bl};
        cyc++;
    endtask

    task automatic step(input logic r, input logic mt, input logic it, input logic il, input string tag);
        exp_t e;
        @(negedge clk);
        rst = r; mode_tick = mt; inc_tick = it; inc_level = il;
        e.tag = tag;
        model_step(r, mt, it, il, e.val);
        sb.push_back(e);
    endtask

    task automatic idle(input int n, input logic il, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, il, tag);
    endtask

    always @(posedge clk) begin
        #1;
        if (hour_inc === 1'b1) hour_seen++;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check(mon_e.tag, {23'd0, mode, run_en, hour_inc, min_inc, sec_clear, blank}, {23'd0, mon_e.val});
        end
    end

    initial begin
        step(1'b1, 1'b0, 1'b0, 1'b0, "reset");
        step(1'b1, 1'b0, 1'b0, 1'b0, "reset");

        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, "mode_walk");
            idle(4, 1'b0, "mode_walk");
        end

        step(1'b0, 1'b0, 1'b1, 1'b0, "run_inc_ignored");
        idle(2, 1'b0, "run_inc_ignored");
        step(1'b0, 1'b1, 1'b0, 1'b0, "to_hour");
        idle(2, 1'b0, "to_hour");
        step(1'b0, 1'b1, 1'b0, 1'b0, "to_min");
        idle(2, 1'b0, "to_min");
        step(1'b0, 1'b0, 1'b1, 1'b0, "min_inc");
        idle(2, 1'b0, "min_inc");
        step(1'b0, 1'b1, 1'b0, 1'b0, "to_sec");
        idle(1, 1'b0, "to_sec");
        step(1'b0, 1'b0, 1'b1, 1'b0, "sec_clear");
        idle(2, 1'b0, "sec_clear");
        step(1'b0, 1'b1, 1'b0, 1'b0, "to_run");
        idle(1, 1'b0, "to_run");

        step(1'b0, 1'b1, 1'b0, 1'b0, "simul_setup");
        idle(1, 1'b0, "simul_setup");
        step(1'b0, 1'b1, 1'b1, 1'b0, "mt_and_it");
        idle(2, 1'b0, "mt_and_it");
        step(1'b0, 1'b1, 1'b0, 1'b0, "simul_exit");
        step(1'b0, 1'b1, 1'b0, 1'b0, "simul_exit");

        step(1'b0, 1'b1, 1'b0, 1'b0, "blink_timeout");
        idle(22, 1'b0, "blink_timeout");
        step(1'b0, 1'b1, 1'b0, 1'b0, "timeout_ext");
        idle(14, 1'b0, "timeout_ext");
        step(1'b0, 1'b0, 1'b1, 1'b0, "timeout_ext_inc");
        idle(22, 1'b0, "timeout_ext");

        step(1'b0, 1'b1, 1'b0, 1'b0, "rep_enter");
        hour_seen = 0;
        step(1'b0, 1'b0, 1'b1, 1'b1, "rep_hold");
        idle(19, 1'b1, "rep_hold");
        idle(6, 1'b0, "rep_release");
        check("rep_count", hour_seen, REP_EN ? 5 : 1);

        step(1'b0, 1'b1, 1'b0, 1'b0, "to_min2");
        step(1'b0, 1'b1, 1'b0, 1'b0, "to_sec2");
        step(1'b0, 1'b0, 1'b1, 1'b1, "sec_no_repeat");
        idle(11, 1'b1, "sec_no_repeat");
        idle(4, 1'b0, "sec_blink");
        step(1'b1, 1'b0, 1'b0, 1'b0, "rst_mid");
        idle(2, 1'b0, "after_rst");

        @(posedge clk);
        #2;
        check("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
- Sequences the digital clock's timekeeping datapath between normal running and manual time setting.
- Consumes debounced, edge-narrowed button pulses and issues single-cycle increment/clear strobes to the hour/minute/second counters.
- Drives run enable, per-field display blanking for blink, and the current mode code.
- Returns automatically to RUN after an idle timeout.

Parameters:
- BLINK_CYC, 25_000_000: cycles per blink half-period, ≥2.
- TIMEOUT_CYC, 500_000_000: idle cycles in a set state before forced return to RUN, ≥2.
- REPEAT_DELAY_CYC, 25_000_000: hold cycles before auto-repeat starts (AUTO_REPEAT_EN only).
- REPEAT_RATE_CYC, 5_000_000: cycles between auto-repeat strobes (AUTO_REPEAT_EN only).

Ports:
- clk, input, 1: system clock; single clock domain.
- rst, input, 1: reset, synchronous, active-high.
- mode_tick, input, 1: one-cycle pulse, mode button pressed (already debounced/narrowed).
- inc_tick, input, 1: one-cycle pulse, increment button pressed.
- inc_level, input, 1: debounced increment-button level; used only with AUTO_REPEAT_EN.
- mode, output, 2: 00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC.
- run_en, output, 1: high in RUN; gates the 1 Hz seconds advance.
- hour_inc, output, 1: one-cycle strobe, hour counter +1 (counter wraps itself).
- min_inc, output, 1: one-cycle strobe, minute counter +1; no carry into hours.
- sec_clear, output, 1: one-cycle strobe, seconds := 0.
- blank, output, 3: {hour, min, sec} display blank; 1 means blanked.

Behaviour:
- All outputs registered.
- Reset (rst high at a clk edge), value on the next edge: mode=00, run_en=1, strobes=0, blank=000, all internal counters 0, blink_phase=1.
- Reset mid-operation aborts everything with no partial strobes.
- FSM: RUN→SET_HOUR→SET_MIN→SET_SEC→RUN, one step per mode_tick. mode and run_en update on the edge that samples mode_tick.
- Increment, sampled at edge N, output high for exactly one cycle after edge N:
  - SET_HOUR: inc_tick gives hour_inc.
  - SET_MIN: inc_tick gives min_inc.
  - SET_SEC: inc_tick gives sec_clear.
  - RUN: inc_tick is ignored.
- Simultaneous mode_tick and inc_tick: mode advances, inc is dropped, no strobe.
- Idle timeout:
  - idle_cnt clears on entering a set state and on any mode_tick, inc_tick or repeat strobe.
  - Otherwise idle_cnt increments each cycle in a set state.
  - When idle_cnt reaches TIMEOUT_CYC-1: next state RUN, run_en=1, no strobe emitted. idle_cnt is held at 0 in RUN.
- Blink:
  - In a set state, blink_cnt counts 0..BLINK_CYC-1 and wraps; blink_phase toggles on each wrap.
  - Entering a set state or any increment strobe sets blink_phase=1 and blink_cnt=0, so the field stays visible while being edited.
  - blank bit for the active field = ~blink_phase; other bits = 0.
  - RUN: blank=000.
- Width rules: each counter is wide enough to hold parameter-1 ($clog2 sizing); counters never overflow, they wrap or saturate exactly as stated above.

Optional Feature:
- Macro: TIME_SET_AUTO_REPEAT_EN.
- Defined (SET_HOUR/SET_MIN only):
  - While inc_level=1, hold_cnt counts.
  - After REPEAT_DELAY_CYC cycles of continuous hold, emit one strobe, then one every REPEAT_RATE_CYC cycles.
  - inc_level=0, a mode change, a timeout or reset clears hold_cnt.
  - The initial inc_tick strobe still occurs normally.
  - SET_SEC never auto-repeats.
- Undefined: inc_level is unused, hold logic is absent, and strobes come only from inc_tick.

Test Plan:
- Bench parameters: BLINK_CYC=4, TIMEOUT_CYC=20, REPEAT_DELAY_CYC=8, REPEAT_RATE_CYC=3.
- Reset then 4 mode_tick pulses 5 cycles apart -> mode 00→01→10→11→00, each change one cycle after the pulse; run_en=0 only while mode≠00.
- In SET_MIN, inc_tick at edge 10 -> min_inc high only during cycle 11; hour_inc=0, sec_clear=0. Same pulse in RUN -> no strobe.
- mode_tick and inc_tick together in SET_HOUR -> mode=10, hour_inc stays 0.
- Enter SET_HOUR with no further input -> blank[2] pattern is 0 for 4 cycles, then 1 for 4, then repeats; mode returns to 00 20 cycles after entry; an inc_tick at cycle 15 pushes the return to cycle 35.
- With macro defined: SET_HOUR, inc_tick plus inc_level held for 20 cycles -> hour_inc at cycle 1, then at cycles 9, 12, 15, 18; none after release. Without macro -> only the cycle-1 strobe.
- rst asserted mid-blink in SET_SEC -> next edge mode=00, blank=000, run_en=1, no strobes.
